// File: rtl/eth_rx_mac.sv
// eth_rx_mac: GMII receive front end that strips preamble/SFD, holds back the FCS, and checks CRC, errors and length.
// Define ETH_RX_MAC_STATS_EN to build the good/bad frame counters; otherwise those ports are tied to 0.
module eth_rx_mac #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514
) (
    input  logic        eth_rx_clk,
    input  logic        rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  eth_rx_data,
    output logic        eth_rx_data_valid,
    output logic        eth_rx_frame_good,
    output logic        eth_rx_frame_bad,
    output logic [15:0] frames_good_cnt,
    output logic [15:0] frames_bad_cnt
);
    localparam int CW = $clog2(MAX_LEN + 6);
    localparam logic [CW-1:0] L_FWD = CW'(4);
    localparam logic [CW-1:0] L_LO  = CW'(MIN_LEN + 4);
    localparam logic [CW-1:0] L_HI  = CW'(MAX_LEN + 4);
    localparam logic [CW-1:0] L_SAT = CW'(MAX_LEN + 5);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    state_t          r_state;
    logic [31:0]     r_crc;
    logic [CW-1:0]   r_cnt;
    logic [3:0][7:0] r_dly;
    logic            r_err;
    logic [31:0]     w_crc_rev;
    logic            w_good;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // The register runs LSB-first; the magic residue is quoted MSB-first.
    always_comb
        for (int k = 0; k < 32; k++)
            w_crc_rev[k] = r_crc[31-k];

    assign w_good = (w_crc_rev == 32'hC704DD7B) && !r_err && (r_cnt >= L_LO) && (r_cnt <= L_HI);

    always_ff @(posedge eth_rx_clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_crc             <= 32'hFFFFFFFF;
            r_cnt             <= '0;
            r_dly             <= '0;
            r_err             <= 1'b0;
            eth_rx_data       <= 8'd0;
            eth_rx_data_valid <= 1'b0;
            eth_rx_frame_good <= 1'b0;
            eth_rx_frame_bad  <= 1'b0;
        end else begin
            eth_rx_data_valid <= 1'b0;
            eth_rx_frame_good <= 1'b0;
            eth_rx_frame_bad  <= 1'b0;
            case (r_state)
                S_IDLE:
                    if (gmii_rx_dv)
                        r_state <= (gmii_rxd == 8'h55) ? S_PRE : S_DROP;
                S_PRE:
                    if (!gmii_rx_dv)
                        r_state <= S_IDLE;
                    else if (gmii_rxd == 8'hD5) begin
                        r_state <= S_DATA;
                        r_crc   <= 32'hFFFFFFFF;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end else if (gmii_rxd != 8'h55)
                        r_state <= S_DROP;
                S_DATA:
                    if (gmii_rx_dv) begin
                        r_dly <= {r_dly[2:0], gmii_rxd};
                        r_crc <= crc_next(r_crc, gmii_rxd);
                        r_cnt <= (r_cnt == L_SAT) ? r_cnt : r_cnt + 1'b1;
                        if (gmii_rx_er)
                            r_err <= 1'b1;
                        if (r_cnt >= L_FWD && r_cnt < L_HI) begin
                            eth_rx_data       <= r_dly[3];
                            eth_rx_data_valid <= 1'b1;
                        end
                    end else begin
                        r_state           <= S_IDLE;
                        eth_rx_frame_good <= w_good;
                        eth_rx_frame_bad  <= !w_good;
                    end
                S_DROP:
                    if (!gmii_rx_dv)
                        r_state <= S_IDLE;
                default:
                    r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ETH_RX_MAC_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    always_ff @(posedge eth_rx_clk or posedge rst) begin
        if (rst) begin
            r_good_cnt <= 16'd0;
            r_bad_cnt  <= 16'd0;
        end else begin
            if (eth_rx_frame_good)
                r_good_cnt <= r_good_cnt + 16'd1;
            if (eth_rx_frame_bad)
                r_bad_cnt <= r_bad_cnt + 16'd1;
        end
    end

    assign frames_good_cnt = r_good_cnt;
    assign frames_bad_cnt  = r_bad_cnt;
`else
    assign frames_good_cnt = 16'd0;
    assign frames_bad_cnt  = 16'd0;
`endif
endmodule
